// File: rtl/yags_history_unit_if.sv
// rtl/yags_history_unit_if.sv - predict/resolve/update bundle between fetch, the history unit and the PHT
// master drives predictions and resolutions; slave (the history unit) answers with ready and update pulses.
interface yags_history_unit_if #(
  parameter int GHR_SIZE = 10,
  parameter int PC_SIZE  = 10
);
  logic                pred_valid;
  logic [PC_SIZE-1:0]  pred_pc;
  logic                pred_taken;
  logic                pred_ready;
  logic                resolve_valid;
  logic                resolve_taken;
  logic                upd_update;
  logic                upd_miss_predict;
  logic [PC_SIZE-1:0]  upd_address;
  logic [GHR_SIZE-1:0] upd_history;
  logic [1:0]          upd_actual_prediction;

  modport master (
    output pred_valid, pred_pc, pred_taken, resolve_valid, resolve_taken,
    input  pred_ready, upd_update, upd_miss_predict, upd_address, upd_history,
           upd_actual_prediction
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, resolve_valid, resolve_taken,
    output pred_ready, upd_update, upd_miss_predict, upd_address, upd_history,
           upd_actual_prediction
  );
endinterface

// File: rtl/yags_history_unit.sv
// rtl/yags_history_unit.sv - speculative GHR and in-flight branch queue feeding the YAGS PHT
// Optional resolve/mispredict counters are built when YAGS_HISTORY_STATS_EN is defined.
module yags_history_unit #(
  parameter int GHR_SIZE   = 10,
  parameter int PC_SIZE    = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  yags_history_unit_if.slave          bus,
  output logic [GHR_SIZE-1:0]         read_history,
  output logic                        flush,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        resolve_underflow
`ifdef YAGS_HISTORY_STATS_EN
  ,
  output logic [31:0]                 stat_resolved,
  output logic [31:0]                 stat_mispredicted
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_SIZE-1:0]  pc_mem   [FIFO_DEPTH];
  logic                tk_mem   [FIFO_DEPTH];
  logic [GHR_SIZE-1:0] snap_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [GHR_SIZE-1:0] ghr;

  logic                upd_update_q;
  logic                upd_miss_q;
  logic [PC_SIZE-1:0]  upd_address_q;
  logic [GHR_SIZE-1:0] upd_history_q;
  logic [1:0]          upd_act_q;

  logic                ready;
  logic                res_ok;
  logic                mispred;
  logic                push;
  logic                pop;
  logic [PC_SIZE-1:0]  head_pc;
  logic                head_taken;
  logic [GHR_SIZE-1:0] head_snap;

  assign head_pc    = pc_mem[rd_ptr];
  assign head_taken = tk_mem[rd_ptr];
  assign head_snap  = snap_mem[rd_ptr];

  // No bypass: a full queue refuses a prediction even while it pops.
  assign ready   = (count != CNT_W'(FIFO_DEPTH));
  assign res_ok  = bus.resolve_valid && (count != '0);
  assign mispred = res_ok && (head_taken != bus.resolve_taken);
  assign push    = bus.pred_valid && ready && !mispred;
  assign pop     = res_ok;

  assign bus.pred_ready            = ready;
  assign bus.upd_update            = upd_update_q;
  assign bus.upd_miss_predict      = upd_miss_q;
  assign bus.upd_address           = upd_address_q;
  assign bus.upd_history           = upd_history_q;
  assign bus.upd_actual_prediction = upd_act_q;
  assign read_history              = ghr;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.pred_pc;
      tk_mem[wr_ptr]   <= bus.pred_taken;
      snap_mem[wr_ptr] <= ghr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispred) begin
      // Repair history from the wrong branch's snapshot with its real outcome.
      ghr    <= {head_snap[GHR_SIZE-2:0], bus.resolve_taken};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ghr    <= {ghr[GHR_SIZE-2:0], bus.pred_taken};
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_update_q      <= 1'b0;
      upd_miss_q        <= 1'b0;
      upd_address_q     <= '0;
      upd_history_q     <= '0;
      upd_act_q         <= 2'b00;
      flush             <= 1'b0;
      resolve_underflow <= 1'b0;
    end else begin
      upd_update_q  <= res_ok;
      upd_miss_q    <= mispred;
      upd_address_q <= res_ok ? head_pc : '0;
      upd_history_q <= res_ok ? head_snap : '0;
      upd_act_q     <= (res_ok && bus.resolve_taken) ? 2'b11 : 2'b00;
      flush         <= mispred;
      if (bus.resolve_valid && (count == '0)) begin
        resolve_underflow <= 1'b1;
      end
    end
  end

`ifdef YAGS_HISTORY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved     <= '0;
      stat_mispredicted <= '0;
    end else begin
      if (res_ok && (stat_resolved != 32'hFFFF_FFFF)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (mispred && (stat_mispredicted != 32'hFFFF_FFFF)) begin
        stat_mispredicted <= stat_mispredicted + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_yags_history_unit.sv
// tb/tb_yags_history_unit.sv - scoreboard bench for yags_history_unit
// A queue-based reference model predicts GHR/occupancy; expected PHT updates are queued at resolve time.
module tb_yags_history_unit;
  localparam int G = 10;
  localparam int P = 10;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic [G-1:0] read_history;
  logic         flush;
  logic [3:0]   count;
  logic         resolve_underflow;
`ifdef YAGS_HISTORY_STATS_EN
  logic [31:0]  stat_resolved;
  logic [31:0]  stat_mispredicted;
`endif

  yags_history_unit_if #(.GHR_SIZE(G), .PC_SIZE(P)) bus ();

  yags_history_unit #(.GHR_SIZE(G), .PC_SIZE(P), .FIFO_DEPTH(D)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .read_history      (read_history),
    .flush             (flush),
    .count             (count),
    .resolve_underflow (resolve_underflow)
`ifdef YAGS_HISTORY_STATS_EN
    ,
    .stat_resolved     (stat_resolved),
    .stat_mispredicted (stat_mispredicted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0] pc;
    logic         taken;
    logic [G-1:0] snap;
  } ent_t;

  typedef struct {
    logic         miss;
    logic [P-1:0] addr;
    logic [G-1:0] hist;
    logic [1:0]   act;
  } exp_t;

  ent_t         m_q[$];
  exp_t         sb[$];
  logic [G-1:0] m_ghr;
  logic         m_uf;
  logic         m_flush;
  int unsigned  m_res;
  int unsigned  m_mis;
  int           total;
  int           bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    sb.delete();
    m_ghr   = '0;
    m_uf    = 1'b0;
    m_flush = 1'b0;
    m_res   = 0;
    m_mis   = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_count", count, 0);
    check("rst_ghr", read_history, 0);
    check("rst_flush", flush, 0);
    check("rst_upd", bus.upd_update, 0);
    check("rst_miss", bus.upd_miss_predict, 0);
    check("rst_addr", bus.upd_address, 0);
    check("rst_hist", bus.upd_history, 0);
    check("rst_act", bus.upd_actual_prediction, 0);
    check("rst_uf", resolve_underflow, 0);
`ifdef YAGS_HISTORY_STATS_EN
    check("rst_stat_res", stat_resolved, 0);
    check("rst_stat_mis", stat_mispredicted, 0);
`endif
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic pv, input logic [P-1:0] pc, input logic pt,
                       input logic rv, input logic rt);
    logic ready;
    logic res_ok;
    logic mis;
    logic push;
    ent_t h;
    exp_t e;
    bus.pred_valid    = pv;
    bus.pred_pc       = pc;
    bus.pred_taken    = pt;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    ready  = (m_q.size() != D);
    check("pred_ready", bus.pred_ready, ready);
    res_ok = rv && (m_q.size() > 0);
    mis    = 1'b0;
    h      = '{pc: '0, taken: 1'b0, snap: '0};
    if (res_ok) begin
      h   = m_q[0];
      mis = (h.taken != rt);
      sb.push_back('{miss: mis, addr: h.pc, hist: h.snap, act: rt ? 2'b11 : 2'b00});
    end
    if (rv && m_q.size() == 0) m_uf = 1'b1;
    push = pv && ready && !mis;
    @(posedge clk);
    #1;
    if (mis) begin
      m_ghr = {h.snap[G-2:0], rt};
      m_q.delete();
    end else begin
      if (res_ok) m_q.delete(0);
      if (push) begin
        m_q.push_back('{pc: pc, taken: pt, snap: m_ghr});
        m_ghr = {m_ghr[G-2:0], pt};
      end
    end
    m_flush = mis;
    if (res_ok) m_res++;
    if (mis) m_mis++;
    bus.pred_valid    = 1'b0;
    bus.resolve_valid = 1'b0;
    check("ghr", read_history, m_ghr);
    check("count", count, m_q.size());
    check("flush", flush, m_flush);
    check("underflow", resolve_underflow, m_uf);
`ifdef YAGS_HISTORY_STATS_EN
    check("stat_res", stat_resolved, m_res);
    check("stat_mis", stat_mispredicted, m_mis);
`endif
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("upd_update", bus.upd_update, 1);
      check("upd_miss", bus.upd_miss_predict, e.miss);
      check("upd_addr", bus.upd_address, e.addr);
      check("upd_hist", bus.upd_history, e.hist);
      check("upd_act", bus.upd_actual_prediction, e.act);
    end else begin
      check("upd_idle", bus.upd_update, 0);
      check("upd_idle_miss", bus.upd_miss_predict, 0);
      check("upd_idle_addr", bus.upd_address, 0);
      check("upd_idle_hist", bus.upd_history, 0);
      check("upd_idle_act", bus.upd_actual_prediction, 0);
    end
  endtask

  initial begin
    logic [G-1:0] g;
    logic         rt;
    total = 0;
    bad   = 0;
    bus.pred_valid    = 1'b0;
    bus.pred_pc       = '0;
    bus.pred_taken    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    rst_n = 1'b0;
    do_reset();

    // three taken predictions, then a correct resolve
    cycle(1, 10'h004, 1, 0, 0);
    cycle(1, 10'h008, 1, 0, 0);
    cycle(1, 10'h00C, 1, 0, 0);
    check("dir_ghr3", read_history, 10'b0000000111);
    check("dir_cnt3", count, 3);
    check("dir_ready3", bus.pred_ready, 1);
    cycle(0, 10'h000, 0, 1, 1);
    check("dir_cnt2", count, 2);
    check("dir_ghr_keep", read_history, 10'b0000000111);

    // mispredict with a same-cycle prediction
    do_reset();
    cycle(1, 10'h004, 1, 0, 0);
    cycle(1, 10'h008, 1, 0, 0);
    cycle(1, 10'h00C, 1, 0, 0);
    cycle(1, 10'h3F0, 1, 1, 0);
    check("mis_ghr", read_history, 10'b0);
    check("mis_cnt", count, 0);
    check("mis_flush", flush, 1);
    cycle(0, 10'h000, 0, 0, 0);
    check("flush_pulse", flush, 0);

    // fill to capacity
    for (int i = 0; i < D; i++) cycle(1, P'($urandom), 1'($urandom), 0, 0);
    check("full_cnt", count, 8);
    check("full_ready", bus.pred_ready, 0);
    g = read_history;
    cycle(1, 10'h155, 1, 0, 0);
    check("full_ghr", read_history, g);
    cycle(1, 10'h2AA, 1, 1, m_q[0].taken);
    check("full_res_cnt", count, 7);
    while (m_q.size() > 0) cycle(0, 10'h000, 0, 1, m_q[0].taken);

    // empty-queue resolve sets sticky underflow
    cycle(0, 10'h000, 0, 1, 1);
    check("uf_set", resolve_underflow, 1);
    for (int i = 0; i < 3; i++) cycle(0, 10'h000, 0, 0, 0);
    check("uf_hold", resolve_underflow, 1);

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      rt = 1'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0) rt = m_q[0].taken;
      cycle(1'($urandom), P'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), rt);
    end

    // async reset with 5 entries queued and an update pulse live
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, P'(i * 4 + 4), 1'($urandom), 0, 0);
    cycle(0, 10'h000, 0, 1, m_q[0].taken);
    check("pre_rst_cnt", count, 5);
    do_reset();
    cycle(1, 10'h100, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/yags_history_unit.md
Name: yags_history_unit

Overview:
- Upstream/side stage of the YAGS direction PHT.
- Owns the speculative global history register (GHR) that feeds the PHT read-side history. Holds an in-order queue of in-flight predicted branches.
- On branch resolution, drives the PHT update-side port (address, history, update, miss_predict, actual_prediction) one cycle later.
- On a mispredict, repairs the GHR from the branch's snapshot and flushes all younger in-flight entries.

Parameters:
- GHR_SIZE, 10, global history width in bits; must match the PHT.
- PC_SIZE, 10, PC bits carried per branch; must match the PHT.
- FIFO_DEPTH, 8, in-flight branch capacity; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_valid  in  1  fetch predicted a conditional branch this cycle.
- pred_pc  in  PC_SIZE  PC of that branch.
- pred_taken  in  1  predicted direction (1 = taken).
- pred_ready  out  1  queue can accept; equals (count != FIFO_DEPTH).
- read_history  out  GHR_SIZE  current speculative GHR, to the PHT read_history.
- resolve_valid  in  1  oldest in-flight branch resolved (in program order).
- resolve_taken  in  1  actual direction of the oldest branch.
- upd_update  out  1  one-cycle pulse to the PHT update input.
- upd_miss_predict  out  1  resolved direction differed from the prediction.
- upd_address  out  PC_SIZE  PC of the resolved branch.
- upd_history  out  GHR_SIZE  GHR snapshot taken before this branch's shift.
- upd_actual_prediction  out  2  2'b11 if resolved taken, 2'b00 if not taken.
- flush  out  1  registered pulse; fetch must squash younger speculative work.
- count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- resolve_underflow  out  1  sticky; set when a resolve arrives with the queue empty.

Behaviour:
- Reset (async, rst_n=0):
  - GHR=0, queue empty (count=0), read/write pointers=0.
  - All upd_* outputs=0, flush=0, resolve_underflow=0.
- Predict accept: when pred_valid && pred_ready and no mispredict resolve occurs this cycle:
  - Push {pred_pc, pred_taken, GHR} at the write pointer.
  - GHR <= {GHR[GHR_SIZE-2:0], pred_taken}.
  - count+1.
- read_history:
  - Combinational from the GHR register.
  - Reflects an accepted prediction from the next cycle onward.
- Correct resolve: resolve_valid with count>0, and head.taken == resolve_taken:
  - Pop the head.
  - Next cycle: upd_update=1, upd_miss_predict=0, upd_address=head.pc, upd_history=head.snapshot, upd_actual_prediction from resolve_taken.
  - GHR is not changed by this resolve.
- Mispredict resolve: resolve_valid with count>0, and head.taken != resolve_taken:
  - Same upd_* outputs as a correct resolve, but upd_miss_predict=1.
  - GHR <= {head.snapshot[GHR_SIZE-2:0], resolve_taken}.
  - Queue cleared: count=0, pointers reset to 0.
  - flush=1 on the next cycle.
  - A prediction presented in the same cycle is dropped: it is not pushed and does not shift the GHR.
- Simultaneous correct resolve and predict: both take effect; count unchanged.
- Full queue: pred_ready=0 even if a resolve occurs in the same cycle (no bypass).
- Empty-queue resolve: ignored (no pop, no update pulse); resolve_underflow set and held until reset.
- Pointer width: $clog2(FIFO_DEPTH) bits, wrapping naturally at FIFO_DEPTH.
- Output timing: all upd_* outputs and flush are registered single-cycle pulses; all payload fields return to 0 when upd_update=0.
- Latency: resolve to PHT update is exactly 1 cycle.

Optional Feature:
- Macro: YAGS_HISTORY_STATS_EN.
- When defined, adds output ports stat_resolved[31:0] and stat_mispredicted[31:0]:
  - stat_resolved increments on each valid (non-underflow) resolve.
  - stat_mispredicted increments on each mispredict resolve.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then accept taken predictions at pc 10'h004, 10'h008, 10'h00C -> read_history=10'b0000000111, count=3, pred_ready=1.
- After the above, resolve taken -> next cycle upd_update=1, upd_address=10'h004, upd_history=0, upd_miss_predict=0, upd_actual_prediction=2'b11; count=2; GHR unchanged.
- With 3 entries queued (GHR=10'b111), resolve head not-taken while pred_valid=1 -> GHR=10'b0000000000, count=0, flush=1 next cycle, upd_miss_predict=1, upd_actual_prediction=2'b00, the same-cycle prediction is not queued.
- Push 8 entries -> pred_ready=0 and count=8. A further pred_valid is not accepted and GHR is unchanged. Resolve and predict together while full -> count=7, the new prediction is not accepted.
- Resolve with an empty queue -> upd_update stays 0, resolve_underflow=1 and remains 1 until rst_n is asserted.
- Assert rst_n low mid-stream with 5 entries queued -> count, GHR, flush and upd_* are 0 immediately, without waiting for a clock edge. With YAGS_HISTORY_STATS_EN defined, both stat counters also read 0.
